// File: rtl/core_pipe_pkg.sv
// Shared types and defaults for the core pipeline registers.
package core_pipe_pkg;

  localparam int unsigned XLEN_DEF       = 64;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  // Field order matches the flat packing used inside ex_mem_stage.
  typedef struct packed {
    logic [XLEN_DEF-1:0]       result;
    logic [REG_ADDR_W_DEF-1:0] rd_addr;
    logic                      rd_we;
    logic                      mem_valid;
    logic                      mem_rw;
    mem_size_e                 mem_size;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer on a flat W-bit payload.
// in_ready_o is registered, so out_ready_i has no combinational path to it.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept, pop;

  assign accept = in_valid_i & ready_q;
  assign pop    = (state_q != StEmpty) & out_ready_i;

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Next state and entry movement; flush empties both entries.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data_i;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = in_data_i;
          end else if (accept) begin
            state_d = StTwo;
            skid_d  = in_data_i;
          end else if (pop) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    // Ready next cycle means the skid slot will be free.
    ready_d = (state_d != StTwo);
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid_o = (state_q != StEmpty);
    out_data_o  = main_q;
    in_ready_o  = ready_q;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and bubble zeroing.
// Define EX_MEM_SKID_EN to add a skid entry and register in_ready_o.
module ex_mem_stage
  import core_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN-1:0]       result_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_rw_i,
  input  logic [1:0]            mem_size_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_we_o,
  output logic                  mem_valid_o,
  output logic                  mem_rw_o,
  output logic [1:0]            mem_size_o
);

  localparam int unsigned PW = XLEN + REG_ADDR_W + 5;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] held_pl;
  logic [PW-1:0] out_pl;
  logic          held_valid;

  assign in_pl = {result_i, rd_addr_i, rd_we_i, mem_valid_i, mem_rw_i, mem_size_i};

`ifdef EX_MEM_SKID_EN
  pipe_skid_buf #(
    .W(PW)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pl),
    .out_valid_o (held_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (held_pl)
  );
`else
  logic          valid_q;
  logic [PW-1:0] data_q;

  // Free when empty or when the held entry leaves this cycle.
  assign in_ready_o = ~valid_q | out_ready_i;

  // Single-entry register; flush drops both held and offered entries.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      data_q  <= in_valid_i ? in_pl : '0;
    end
  end

  assign held_valid = valid_q;
  assign held_pl    = data_q;
`endif

  // Bubble rule: an empty stage presents an all-zero payload.
  always_comb begin
    out_valid_o = held_valid;
    out_pl      = held_valid ? held_pl : '0;
  end

  assign {result_o, rd_addr_o, rd_we_o, mem_valid_o, mem_rw_o, mem_size_o} = out_pl;

endmodule
